// File: rtl/usart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usart_pkg
// Description : Shared definitions for the USART transmitter and receiver:
//               frame state encoding, bit-period helper and the idle line
//               level.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package usart_pkg;

    // Frame sequencing states; PARITY is only reachable in parity builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Line level while no frame is on the wire.
    localparam logic IDLE_LEVEL = 1'b1;

    // System clocks per serial bit (integer divide, truncating).
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : usart_baud_gen
// Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last
//               cycle of each bit period. Held at zero while clr_i is high so
//               the first bit after a clear gets its full width.
// Ports       : clk        - system clock
//               reset      - synchronous reset, active-low
//               clr_i      - synchronous counter clear
//               bit_tick_o - high on the last cycle of every bit period
// Revision    : 1.0 - initial release
// ============================================================================
module usart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic bit_tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == CNT_LAST) && !clr_i;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usart_tx.sv
`default_nettype none
// ============================================================================
// Module      : usart_tx
// Description : USART serial transmitter. Accepts one word per valid/ready
//               handshake and sends start bit, data LSB first, optional even
//               parity and STOP_BITS stop bits on a registered tx line.
//               Optional feature macro: USART_TX_PARITY_EN (even parity bit).
// Ports       : clk   - system clock
//               reset - synchronous reset, active-low
//               data  - word to send, sampled on the accept cycle
//               valid - upstream request
//               ready - word can be accepted this cycle (IDLE only)
//               tx    - serial line, idle high
//               busy  - frame in progress
//               done  - one-cycle pulse in the final cycle of the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module usart_tx
    import usart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic                 tx_q,    tx_d;
    logic                 bit_tick;
    logic                 accept;
`ifdef USART_TX_PARITY_EN
    logic                 par_q,   par_d;
`endif

    // Timer is held cleared in IDLE so START always gets a full bit period.
    usart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_q == IDLE),
        .bit_tick_o (bit_tick)
    );

    // ready is gated by reset so nothing is accepted while reset is held.
    assign ready  = (state_q == IDLE) && reset;
    assign busy   = (state_q != IDLE);
    assign accept = valid && ready;
    assign tx     = tx_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done    = 1'b0;
`ifdef USART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data;
                    idx_d   = '0;
                    state_d = START;
`ifdef USART_TX_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
`ifdef USART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
            PARITY: begin
`ifdef USART_TX_PARITY_EN
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (bit_tick) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so it is derived from the next state: the line
        // level changes on the same edge as the state.
        tx_d = IDLE_LEVEL;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef USART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
`ifdef USART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
`ifdef USART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_usart_tx
// Description : Self-checking bench for usart_tx. Two instances: one with one
//               stop bit, one with two. Expected line levels come from a frame
//               model that lists the bits of a frame and expands each to
//               CLKS_PER_BIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usart_tx;

    localparam int CF  = 100;
    localparam int BR  = 10;
    localparam int CPB = CF / BR;
    localparam int DB  = 8;
`ifdef USART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          valid = 1'b0;
    logic          sel   = 1'b0;

    logic valid1, valid2;
    logic ready1, tx1, busy1, done1;
    logic ready2, tx2, busy2, done2;
    logic cur_ready, cur_tx, cur_busy, cur_done;

    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];

    always #5 clk = ~clk;

    assign valid1    = valid & ~sel;
    assign valid2    = valid & sel;
    assign cur_ready = sel ? ready2 : ready1;
    assign cur_tx    = sel ? tx2    : tx1;
    assign cur_busy  = sel ? busy2  : busy1;
    assign cur_done  = sel ? done2  : done1;

    usart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(DB), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .data(data), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    usart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(DB), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .data(data), .valid(valid2),
        .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as a list of bit levels: start, data LSB first, parity, stops.
    task automatic build_frame(input logic [DB-1:0] w, input int nstop);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DB; i++) exp_q.push_back(w[i]);
        if (P == 1) exp_q.push_back(^w);
        repeat (nstop) exp_q.push_back(1'b1);
    endtask

    // Waits (bounded) for ready, offers w, returns at the first start-bit cycle.
    task automatic send(input logic [DB-1:0] w, input bit keep);
        int n = 0;
        while (cur_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", cur_ready, 1);
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        if (!keep) valid = 1'b0;
    endtask

    // Checks a whole frame cycle by cycle, starting at the first start-bit cycle.
    task automatic check_frame(input logic [DB-1:0] w, input int nstop, input bit noise,
                               input int inj_at, input logic [DB-1:0] inj_w);
        int total;
        int done_at;
        build_frame(w, nstop);
        total   = exp_q.size() * CPB;
        done_at = -1;
        for (int i = 0; i < total; i++) begin
            chk($sformatf("tx@%0d w=%0h", i, w), cur_tx, exp_q[i / CPB]);
            chk($sformatf("done@%0d", i), cur_done, (i == total - 1));
            chk($sformatf("ready@%0d", i), cur_ready, 0);
            chk($sformatf("busy@%0d", i), cur_busy, 1);
            if (cur_done === 1'b1) done_at = i;
            if (noise) begin
                data  = DB'($urandom);
                valid = (i < total - 1) ? 1'($urandom) : 1'b0;
            end
            if (i == inj_at) begin
                data  = inj_w;
                valid = 1'b1;
            end
            @(negedge clk);
        end
        chk("frame_len", done_at + 1, (1 + DB + P + nstop) * CPB);
        chk("ready_after", cur_ready, 1);
        chk("tx_idle_after", cur_tx, 1);
        chk("busy_after", cur_busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] w;

        // Reset state, with valid offered while reset is held.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        data  = 8'h12;
        valid = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx1, 1);
        chk("rst_ready", ready1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_tx2", tx2, 1);
        chk("rst_ready2", ready2, 0);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        chk("rel_ready", ready1, 1);
        chk("rel_busy", busy1, 0);
        chk("rel_tx", tx1, 1);
        @(negedge clk);

        // Single frame.
        send(8'hA5, 1'b0);
        check_frame(8'hA5, 1, 1'b0, -1, '0);

        // Back-to-back with valid held high.
        send(8'h00, 1'b1);
        check_frame(8'h00, 1, 1'b0, -1, '0);
        data = 8'hFF;
        @(negedge clk);
        valid = 1'b0;
        check_frame(8'hFF, 1, 1'b0, -1, '0);

        // Request raised mid-frame is held off until IDLE.
        send(8'hC3, 1'b0);
        check_frame(8'hC3, 1, 1'b0, 37, 8'h3C);
        @(negedge clk);
        valid = 1'b0;
        check_frame(8'h3C, 1, 1'b0, -1, '0);

        // Reset during data bit 3.
        send(8'h55, 1'b0);
        build_frame(8'h55, 1);
        for (int i = 0; i < 4 * CPB + 5; i++) begin
            chk($sformatf("pre_rst_tx@%0d", i), tx1, exp_q[i / CPB]);
            chk($sformatf("pre_rst_done@%0d", i), done1, 0);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", tx1, 1);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_ready", ready1, 0);
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", ready1, 1);
        send(8'h55, 1'b0);
        check_frame(8'h55, 1, 1'b0, -1, '0);

        // Parity examples (plain frames in the default build).
        send(8'h07, 1'b0);
        check_frame(8'h07, 1, 1'b0, -1, '0);

        // Random words with random data/valid noise during the frame.
        repeat (4) begin
            w = DB'($urandom);
            send(w, 1'b0);
            check_frame(w, 1, 1'b1, -1, '0);
        end

        // Two stop bits.
        sel = 1'b1;
        #1;
        send(8'h81, 1'b0);
        check_frame(8'h81, 2, 1'b0, -1, '0);
        w = DB'($urandom);
        send(w, 1'b0);
        check_frame(w, 2, 1'b1, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usart_tx.md
Name: usart_tx

Overview:
Serial transmitter paired with the USART receiver; drives the line the receiver samples.
- Accepts one DATA_BITS word per valid/ready handshake and serialises it as one frame: start bit (0), data bits LSB first, optional parity, STOP_BITS stop bits (1).
- Sits between the host-side command/response logic and the physical tx pin.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide), must be >= 2
DATA_BITS, 8, data bits per frame, 5..9
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
data  input  DATA_BITS  word to send; sampled only on the accept cycle
valid  input  1  data valid request from upstream
ready  output  1  block can accept a word this cycle
tx  output  1  registered serial line output, idle high
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse on completion of a frame's final stop bit

Behaviour:
- Reset (reset == 0 at a rising edge): next cycle tx = 1, ready = 0 while reset is held, busy = 0, done = 0, state = IDLE, counters = 0, shift register = 0. After reset is released: ready = 1 from the first cycle.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx = 1, ready = 1, busy = 0.
  - Accept occurs when valid && ready at a rising edge.
  - On accept: data is latched into the shift register; next cycle the state is START and tx = 0.
- Bit timing:
  - Each bit holds tx stable for exactly CLKS_PER_BIT cycles.
  - The clock counter runs 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - Counter width is $clog2(CLKS_PER_BIT).
- START: one bit period at 0, then DATA.
- DATA:
  - Transmits shift register bit 0; the register shifts right once per bit.
  - The bit index counts 0..DATA_BITS-1; after the last bit, go to PARITY (if enabled) or STOP.
- STOP:
  - tx = 1 for STOP_BITS bit periods.
  - In the final cycle of the last stop bit, done = 1 for exactly that one cycle.
  - Next cycle: IDLE, ready = 1.
- Frame length, first tx-low cycle through the done cycle inclusive: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity enabled, else 0.
- Back-to-back frames: the minimum gap is one IDLE cycle (the accept cycle) between done and the next start bit. If valid is held high, frames are sent continuously under that rule.
- ready = 0 in all non-IDLE states. valid asserted while busy is ignored; no word is lost if upstream holds valid until ready.
- data or valid changing mid-frame has no effect on the frame in flight.
- Reset mid-frame: frame abandoned; tx = 1 on the next cycle; no done pulse.
- valid == 1 on the same edge that reset is released: not accepted, because ready is 0 during reset. The first accept can occur one cycle later.

Optional Feature:
Macro USART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA. It transmits one even-parity bit (XOR of the latched DATA_BITS word) for one bit period, and frame length includes P = 1. The parity bit is computed at accept time and stored with the word.
- Undefined: no PARITY state and no parity register; DATA goes directly to STOP; P = 0.

Decomposition:
- Shared package usart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - function clks_per_bit(CLK_FREQ, BAUD_RATE)
  - constant IDLE_LEVEL = 1
  - This package is reused by the receiver.
- One natural sub-module, usart_baud_gen:
  - clock-count register with synchronous clear
  - emits bit_tick on the last cycle of each bit period
  - Restarted on accept so the start bit has full width.

Test Plan:
(CLK_FREQ=100, BAUD_RATE=10, so CLKS_PER_BIT = 10; DATA_BITS=8; STOP_BITS=1 unless noted.)
- Single frame: send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; done pulses once at cycle 100 after the first tx-low cycle; ready returns the cycle after.
- Back-to-back: valid held high with 0x00 then 0xFF -> second start bit begins exactly 1 cycle after the first done; 0xFF frame is 0 followed by nine 1 bits.
- Busy handshake: assert valid with 0x3C mid-frame -> ignored until IDLE; 0x3C is sent next, and the in-flight word is not corrupted.
- Reset mid-frame: reset = 0 at data bit 3 of 0x55 -> tx = 1 the next cycle, no done pulse; after release ready = 1 and 0x55 can be resent in full.
- STOP_BITS=2 with 0x81 -> tx stays high for 20 cycles after the last data bit; frame length is 110 cycles.
- Parity: with USART_TX_PARITY_EN defined, 0xA5 -> parity bit 0 and 0x07 -> parity bit 1; frame length is 110 cycles.
